issue_controller: RTL

In-order issue and hazard controller between the decoder stage and the execute stage of the SIMD processor. It takes one decoded instruction per cycle, tracks pending scalar and vector register writes and the NZ flags in a latency scoreboard, and stalls decode on RAW, WAW or writeback-port conflicts. On an issued jump or branch it flushes fetch and squashes the wrong-path slots.

---
 rtl/simd_pkg.sv | 30 +++
 rtl/reg_scoreboard.sv | 38 +++
 rtl/issue_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD processor front end: opcodes, issue FSM
// states, default latencies and the writeback-slot helper.
package simd_pkg;

    localparam logic [3:0] OP_CRGS = 4'b0000;
    localparam logic [3:0] OP_XOR  = 4'b0001;
    localparam logic [3:0] OP_SUM  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_SHFD = 4'b0101;
    localparam logic [3:0] OP_SHFI = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1010;

    localparam int DEF_ALU_LAT        = 3;
    localparam int DEF_MUL_LAT        = 5;
    localparam int DEF_BRANCH_BUBBLES = 2;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } issue_state_t;

    // One-hot mask selecting slot lat of a [7:1] writeback pipe.
    function automatic logic [6:0] slot_mask(input logic [2:0] lat);
        return 7'(7'b1 << (lat - 3'd1));
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Sixteen 3-bit pending-write down-counters for one register file.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [3:0]  load_idx,
    input  logic [2:0]  load_val,
    output logic [15:0] busy,
    output logic [15:0] pending
);

    logic [2:0] cnt [16];

    // A fresh load overrides the decrement of the same counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cnt[i] <= 3'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (load && load_idx == 4'(i))
                    cnt[i] <= load_val;
                else if (cnt[i] != 3'd0)
                    cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    // A count of 1 means the write lands this cycle, so readers may already issue.
    always_comb begin
        busy    = '0;
        pending = '0;
        for (int i = 0; i < 16; i++) begin
            busy[i]    = (cnt[i] != 3'd0);
            pending[i] = (cnt[i] > 3'd1);
        end
    end

endmodule

// File: rtl/issue_controller.sv
// In-order issue and hazard controller between decode and execute: latency
// scoreboard, shared writeback port tracking and branch squash FSM.
module issue_controller
    import simd_pkg::*;
#(
    parameter int ALU_LAT        = DEF_ALU_LAT,
    parameter int MUL_LAT        = DEF_MUL_LAT,
    parameter int BRANCH_BUBBLES = DEF_BRANCH_BUBBLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [3:0]  opcode,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic        rs_vec,
    input  logic [3:0]  RegToWrite,
    input  logic        RegWriteEnSc,
    input  logic        RegWriteEnVec,
    input  logic        OverWriteNz,
    input  logic [2:0]  PcWriteEn,
    output logic        ex_valid,
    output logic [2:0]  ex_lat,
    output logic        flush_fetch,
    output logic [15:0] busy_sc,
    output logic [15:0] busy_vec
);

    localparam logic [2:0] ALU_L = 3'(ALU_LAT);
    localparam logic [2:0] MUL_L = 3'(MUL_LAT);
    localparam int         BW    = $clog2(BRANCH_BUBBLES + 1);

    issue_state_t state, next_state;
    logic [BW-1:0] bubble_cnt;
    logic [2:0]    flags_cnt;
    logic [7:1]    wb_pipe;
    logic [7:1]    wb_shift;
    logic [15:0]   pend_sc, pend_vec, src_pend;
    logic [2:0]    lat;
    logic          writes, is_branch, raw, waw, port_hit, flag_hit, stall, issue;

    assign lat       = (opcode == OP_MUL) ? MUL_L : ALU_L;
    assign writes    = RegWriteEnSc | RegWriteEnVec;
    assign is_branch = (PcWriteEn != 3'd0);
    assign src_pend  = rs_vec ? pend_vec : pend_sc;
    // Compare against the pipe as it will look after this cycle's shift.
    assign wb_shift  = wb_pipe >> 1;

    assign raw      = (rs1_used & src_pend[rs1]) | (rs2_used & src_pend[rs2]);
    assign waw      = (RegWriteEnSc & pend_sc[RegToWrite]) | (RegWriteEnVec & pend_vec[RegToWrite]);
    assign port_hit = writes & (|(wb_shift & slot_mask(lat)));
    assign flag_hit = is_branch & (flags_cnt > 3'd1);
    assign stall    = raw | waw | port_hit | flag_hit;

    reg_scoreboard u_sb_sc (
        .clk      (clk),
        .rst      (rst),
        .load     (issue & RegWriteEnSc),
        .load_idx (RegToWrite),
        .load_val (lat),
        .busy     (busy_sc),
        .pending  (pend_sc)
    );

    reg_scoreboard u_sb_vec (
        .clk      (clk),
        .rst      (rst),
        .load     (issue & RegWriteEnVec),
        .load_idx (RegToWrite),
        .load_val (lat),
        .busy     (busy_vec),
        .pending  (pend_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RUN:    if (issue && is_branch) next_state = SQUASH;
            SQUASH: if (bubble_cnt <= BW'(1)) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // During SQUASH decode is drained: everything is accepted and nothing issues.
    always_comb begin
        id_ready = 1'b0;
        issue    = 1'b0;
        unique case (state)
            RUN: begin
                id_ready = ~stall;
                issue    = id_valid & ~stall;
            end
            SQUASH:  id_ready = 1'b1;
            default: id_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt  <= '0;
            flush_fetch <= 1'b0;
            ex_valid    <= 1'b0;
            ex_lat      <= 3'd0;
            flags_cnt   <= 3'd0;
            wb_pipe     <= '0;
        end else begin
            flush_fetch <= issue & is_branch;
            ex_valid    <= issue;
            ex_lat      <= issue ? lat : 3'd0;
            if (issue && is_branch)
                bubble_cnt <= BW'(BRANCH_BUBBLES);
            else if (bubble_cnt != '0)
                bubble_cnt <= bubble_cnt - BW'(1);
            if (issue && OverWriteNz)
                flags_cnt <= ALU_L;
            else if (flags_cnt != 3'd0)
                flags_cnt <= flags_cnt - 3'd1;
            wb_pipe <= wb_shift | ((issue && writes) ? slot_mask(lat) : 7'd0);
        end
    end

endmodule
